// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 packet router: widths, header field positions,
// destination encodings and the header-to-packet-count helper.
package router_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PKT_CNT_W  = 7;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    typedef enum logic [1:0] {
        DEST_0 = 2'b00,
        DEST_1 = 2'b01,
        DEST_2 = 2'b10
    } dest_e;

    // Bytes still to come after a header: payload length plus the parity byte.
    function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [DATA_W-1:0] hdr);
        return {1'b0, hdr[LEN_MSB:LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array for the router FIFO: one write port, one read
// address port whose data is captured into the owner's output register.
module router_fifo_mem #(
    parameter int DW = 9,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [DEPTH];

    // Entry storage; a hard reset wipes every entry so no stale byte survives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores bytes tagged with a
// header marker and tracks packet boundaries so data_out floats between packets.
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]    wr_ptr_r;
    logic [ADDR_W:0]    rd_ptr_r;
    logic               empty_s;
    logic               full_s;
    logic               wr_fire_s;
    logic               rd_fire_s;
    logic [DATA_W:0]    rd_entry_s;
    logic [PKT_CNT_W-1:0] pkt_cnt_r;
    logic [DATA_W-1:0]  dout_r;
    logic               drive_r;

    // The extra pointer MSB distinguishes a wrapped-full FIFO from an empty one.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                       (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
    assign wr_fire_s = write_enb && !full_s && !soft_reset;
    assign rd_fire_s = read_enb && !empty_s && !soft_reset;

    assign full  = full_s;
    assign empty = empty_s;

    router_fifo_mem #(
        .DW (DATA_W + 1),
        .AW (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_fire_s),
        .wr_addr (wr_ptr_r[ADDR_W-1:0]),
        .wr_data ({lfd_state, data_in}),
        .rd_addr (rd_ptr_r[ADDR_W-1:0]),
        .rd_data (rd_entry_s)
    );

    // Read and write pointers; soft reset flushes without touching the array.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(ADDR_W+1){1'b0}};
            rd_ptr_r <= {(ADDR_W+1){1'b0}};
        end else if (soft_reset) begin
            wr_ptr_r <= {(ADDR_W+1){1'b0}};
            rd_ptr_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Packet byte counter: loaded from a header read, counts down on the rest.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt_r <= {PKT_CNT_W{1'b0}};
        end else if (soft_reset) begin
            pkt_cnt_r <= {PKT_CNT_W{1'b0}};
        end else if (rd_fire_s) begin
            if (rd_entry_s[DATA_W]) begin
                pkt_cnt_r <= hdr_pkt_cnt(rd_entry_s[DATA_W-1:0]);
            end else if (pkt_cnt_r != {PKT_CNT_W{1'b0}}) begin
                pkt_cnt_r <= pkt_cnt_r - 7'd1;
            end else begin
                pkt_cnt_r <= {PKT_CNT_W{1'b0}};
            end
        end
    end

    // Output byte and drive enable; an orphan byte is still presented for one read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_r  <= {DATA_W{1'b0}};
            drive_r <= 1'b1;
        end else if (soft_reset) begin
            drive_r <= 1'b0;
        end else if (rd_fire_s) begin
            dout_r  <= rd_entry_s[DATA_W-1:0];
            drive_r <= 1'b1;
        end else if (pkt_cnt_r == {PKT_CNT_W{1'b0}}) begin
            drive_r <= 1'b0;
        end
    end

    assign data_out = drive_r ? dout_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_router_fifo.sv
// Directed and randomized bench for router_fifo, checked against a queue-based
// model of the FIFO contents, packet count and output drive state.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    wire  [7:0] data_out;
    logic       full;
    logic       empty;

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] q[$];
    int         m_cnt;
    logic       m_drive;
    logic [7:0] m_dq;

    task automatic model_reset();
        q.delete();
        m_cnt   = 0;
        m_drive = 1'b1;
        m_dq    = 8'h00;
    endtask

    task automatic model_edge(input logic we, input logic re, input logic lfd,
                              input logic [7:0] din, input logic srst);
        logic       was_full;
        logic       was_empty;
        logic [8:0] e;
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (srst) begin
            q.delete();
            m_cnt   = 0;
            m_drive = 1'b0;
        end else begin
            if (re && !was_empty) begin
                e       = q.pop_front();
                m_dq    = e[7:0];
                m_drive = 1'b1;
                if (e[8]) m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_drive = 1'b0;
            end
            if (we && !was_full) q.push_back({lfd, din});
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] exp_d;
        logic       exp_full;
        logic       exp_empty;
        logic [6:0] exp_cnt;
        exp_d     = m_drive ? m_dq : 8'hzz;
        exp_full  = (q.size() == 16);
        exp_empty = (q.size() == 0);
        exp_cnt   = 7'(m_cnt);
        n_cmp++;
        assert (data_out === exp_d) else begin
            n_bad++;
            $error("FAIL %s data_out observed=%h expected=%h", tag, data_out, exp_d);
        end
        n_cmp++;
        assert (full === exp_full) else begin
            n_bad++;
            $error("FAIL %s full observed=%b expected=%b", tag, full, exp_full);
        end
        n_cmp++;
        assert (empty === exp_empty) else begin
            n_bad++;
            $error("FAIL %s empty observed=%b expected=%b", tag, empty, exp_empty);
        end
        n_cmp++;
        assert (dut.pkt_cnt_r === exp_cnt) else begin
            n_bad++;
            $error("FAIL %s pkt_cnt observed=%0d expected=%0d", tag, dut.pkt_cnt_r, exp_cnt);
        end
    endtask

    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [7:0] din, input logic srst, input string tag);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = srst;
        @(posedge clock);
        if (reset) model_reset();
        else model_edge(we, re, lfd, din, srst);
        #1;
        check(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        #1 reset = 1'b1;
        #1 model_reset();
        check(tag);
        step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, {tag, "_held"});
        step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, {tag, "_held2"});
        #3 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        model_reset();
        step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0, "por_held");
        #3 reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "post_por_idle");

        // Single packet: header len=3, three payload bytes, parity.
        step(1'b1, 1'b0, 1'b1, 8'h0C, 1'b0, "pkt_hdr");
        step(1'b1, 1'b0, 1'b0, 8'hA1, 1'b0, "pkt_a1");
        step(1'b1, 1'b0, 1'b0, 8'hA2, 1'b0, "pkt_a2");
        step(1'b1, 1'b0, 1'b0, 8'hA3, 1'b0, "pkt_a3");
        step(1'b1, 1'b0, 1'b0, 8'h5E, 1'b0, "pkt_par");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "pkt_read");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "pkt_idle_z");

        // Fill to full from an offset pointer, overflow, then drain across the wrap.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, "fill");
        step(1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, "overflow_drop");
        step(1'b1, 1'b1, 1'b0, 8'hD1, 1'b0, "rw_when_full");
        step(1'b1, 1'b1, 1'b0, 8'hD2, 1'b0, "rw_at_15");
        step(1'b1, 1'b0, 1'b0, 8'hD3, 1'b0, "refill");
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "drain");

        // Steady occupancy of 5 under concurrent read and write.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, "occ_fill");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0, "occ5_rw");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "occ_drain");

        // Soft reset mid-packet with a read in the same cycle.
        step(1'b1, 1'b0, 1'b1, 8'h18, 1'b0, "sr_hdr");
        step(1'b1, 1'b0, 1'b0, 8'h61, 1'b0, "sr_b1");
        step(1'b1, 1'b0, 1'b0, 8'h62, 1'b0, "sr_b2");
        step(1'b1, 1'b0, 1'b0, 8'h63, 1'b0, "sr_b3");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "sr_rd1");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "sr_rd2");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "sr_pulse");
        step(1'b1, 1'b0, 1'b1, 8'h04, 1'b0, "sr_new_hdr");
        step(1'b1, 1'b0, 1'b0, 8'hB1, 1'b0, "sr_new_b1");
        step(1'b1, 1'b0, 1'b0, 8'hC7, 1'b0, "sr_new_par");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "sr_new_rd");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "sr_new_idle");

        // Orphan byte and zero-length packet.
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "orph_srst");
        step(1'b1, 1'b0, 1'b0, 8'h77, 1'b0, "orph_wr");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "orph_rd");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "orph_idle_z");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "rd_when_empty");
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, "zlen_hdr");
        step(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, "zlen_par");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "zlen_rd_hdr");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "zlen_rd_par");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "zlen_idle");

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 8'($urandom),
                 1'($urandom_range(0, 31) == 0), "random");
        end

        // Hard reset mid-packet: nothing written before it may be read afterwards.
        step(1'b1, 1'b0, 1'b1, 8'h0C, 1'b0, "hr_hdr");
        step(1'b1, 1'b0, 1'b0, 8'h91, 1'b0, "hr_b1");
        step(1'b1, 1'b1, 1'b0, 8'h92, 1'b0, "hr_b2");
        async_reset_pulse("hr_async");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "hr_after_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
